// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Hazard controller for the 5-stage ARM-subset core. It sits at the ID stage,
// next to the forwarding unit, and makes three decisions every cycle:
//   * stall : freeze PC and IF/ID and inject a bubble into ID/EX, because the
//             ID instruction reads a register that is not available yet
//   * flush : discard the fetched instruction because a branch resolved taken
//   * it also runs a watchdog on runs of consecutive stall cycles and keeps
//     saturating stall/flush event counters for debug readout
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous, active-high reset
//   forward_en    1: forwarding active, only load-use hazards stall
//                 0: every RAW hazard against EXE or MEM stalls
//   id_valid      ID holds a real instruction
//   src1, src2    ID source registers (src2 only used when two_src=1)
//   two_src       ID instruction reads src2
//   exe_wb_en     EXE-stage instruction writes back
//   exe_dest      EXE-stage destination register
//   exe_mem_read  EXE-stage instruction is a load
//   mem_wb_en     MEM-stage instruction writes back
//   mem_dest      MEM-stage destination register
//   branch_taken  branch resolved taken in EXE this cycle
//   stall         combinational stall request
//   flush         combinational IF/ID clear
//   hang_err      sticky watchdog error, cleared only by rst
//   stall_cycles  saturating count of stall cycles
//   flush_events  saturating count of flush cycles
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int REG_W     = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush,
  output logic             hang_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Run counter must hold values 0 .. MAX_STALL+1.
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_ZERO  = RUN_W'(0);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    STALLING = 1'b1
  } state_t;

  // Saturating increment: an all-ones counter holds instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // True when the ID instruction reads the given destination register.
  // Matching is purely by value; no register number is special.
  function automatic logic reads_reg(input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] s1,
                                     input logic [REG_W-1:0] s2,
                                     input logic             uses_s2);
    return (s1 == dest) | (uses_s2 & (s2 == dest));
  endfunction

  logic             m_exe_s;
  logic             m_mem_s;
  logic             hazard_s;
  logic             stall_s;
  logic             flush_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [RUN_W-1:0] run_cnt_r;
  logic [RUN_W-1:0] run_cnt_nxt_s;
  logic             trip_s;
  logic             hang_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Hazard detection and the zero-latency stall/flush decision.
  always_comb begin
    m_exe_s  = exe_wb_en & reads_reg(exe_dest, src1, src2, two_src);
    m_mem_s  = mem_wb_en & reads_reg(mem_dest, src1, src2, two_src);
    hazard_s = 1'b0;
    if (forward_en) begin
      // MEM results are forwarded; only a load still in EXE is unavailable.
      hazard_s = id_valid & m_exe_s & exe_mem_read;
    end else begin
      hazard_s = id_valid & (m_exe_s | m_mem_s);
    end
    // A taken branch discards the ID instruction, so its hazard is void.
    stall_s = hazard_s & ~branch_taken;
    flush_s = branch_taken;
  end

  assign stall = stall_s;
  assign flush = flush_s;

  // Next state of the stall-run tracker and the watchdog trip condition.
  always_comb begin
    state_nxt_s   = RUN;
    run_cnt_nxt_s = RUN_ZERO;
    trip_s        = 1'b0;
    case (state_r)
      RUN: begin
        if (stall_s) begin
          state_nxt_s   = STALLING;
          run_cnt_nxt_s = RUN_ONE;
        end else begin
          state_nxt_s   = RUN;
          run_cnt_nxt_s = RUN_ZERO;
        end
      end
      STALLING: begin
        if (stall_s) begin
          state_nxt_s = STALLING;
          if (run_cnt_r >= RUN_SAT) begin
            run_cnt_nxt_s = RUN_SAT;
          end else begin
            run_cnt_nxt_s = run_cnt_r + RUN_ONE;
          end
        end else begin
          state_nxt_s   = RUN;
          run_cnt_nxt_s = RUN_ZERO;
        end
      end
      default: begin
        state_nxt_s   = RUN;
        run_cnt_nxt_s = RUN_ZERO;
      end
    endcase
    // The run count saturates above MAX_STALL, so the trip stays reachable
    // for as long as the run continues.
    if (stall_s && (run_cnt_nxt_s > RUN_LIMIT)) begin
      trip_s = 1'b1;
    end else begin
      trip_s = 1'b0;
    end
  end

  // State, watchdog and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      run_cnt_r   <= RUN_ZERO;
      hang_r      <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      run_cnt_r <= run_cnt_nxt_s;
      if (trip_s) begin
        hang_r <= 1'b1;
      end else begin
        hang_r <= hang_r;
      end
      if (stall_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hang_err     = hang_r;
  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_controller
//
// Directed bench for hazard_stall_controller (REG_W=4, CNT_W=4, MAX_STALL=3).
// A behavioural model tracks the expected outputs from the hazard rules using
// plain integers; a negedge process compares every output against it. Directed
// steps add literal expectations at the points of interest.
// -----------------------------------------------------------------------------
module tb_hazard_stall_controller;

  localparam int REG_W     = 4;
  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             forward_en;
  logic             id_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             two_src;
  logic             exe_wb_en;
  logic [REG_W-1:0] exe_dest;
  logic             exe_mem_read;
  logic             mem_wb_en;
  logic [REG_W-1:0] mem_dest;
  logic             branch_taken;
  logic             stall;
  logic             flush;
  logic             hang_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state
  int consec = 0;
  bit m_hang = 1'b0;
  int m_sc   = 0;
  int m_fe   = 0;

  hazard_stall_controller #(
    .REG_W    (REG_W),
    .CNT_W    (CNT_W),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .forward_en  (forward_en),
    .id_valid    (id_valid),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .exe_wb_en   (exe_wb_en),
    .exe_dest    (exe_dest),
    .exe_mem_read(exe_mem_read),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .branch_taken(branch_taken),
    .stall       (stall),
    .flush       (flush),
    .hang_err    (hang_err),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stall: which in-flight producers still block the ID instruction.
  function automatic bit model_stall();
    bit reads_exe, reads_mem, blocked;
    if (!id_valid || branch_taken) return 1'b0;
    reads_exe = (src1 == exe_dest) || (two_src && (src2 == exe_dest));
    reads_mem = (src1 == mem_dest) || (two_src && (src2 == mem_dest));
    blocked = 1'b0;
    if (exe_wb_en && reads_exe && (!forward_en || exe_mem_read)) blocked = 1'b1;
    if (!forward_en && mem_wb_en && reads_mem) blocked = 1'b1;
    return blocked;
  endfunction

  // Model update at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      consec = 0;
      m_hang = 1'b0;
      m_sc   = 0;
      m_fe   = 0;
    end else begin
      if (model_stall()) begin
        consec = consec + 1;
        if (consec > MAX_STALL) m_hang = 1'b1;
        if (m_sc < CNT_MAX) m_sc = m_sc + 1;
      end else begin
        consec = 0;
      end
      if (branch_taken && m_fe < CNT_MAX) m_fe = m_fe + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", int'(stall), int'(model_stall()));
      chk("m_flush", int'(flush), int'(branch_taken));
      chk("m_hang", int'(hang_err), int'(m_hang));
      chk("m_stall_cycles", int'(stall_cycles), m_sc);
      chk("m_flush_events", int'(flush_events), m_fe);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_in();
    forward_en   = 1'b0;
    id_valid     = 1'b0;
    src1         = 4'd0;
    src2         = 4'd0;
    two_src      = 1'b0;
    exe_wb_en    = 1'b0;
    exe_dest     = 4'd0;
    exe_mem_read = 1'b0;
    mem_wb_en    = 1'b0;
    mem_dest     = 4'd0;
    branch_taken = 1'b0;
  endtask

  task automatic load_use();
    forward_en   = 1'b1;
    id_valid     = 1'b1;
    src1         = 4'd3;
    exe_wb_en    = 1'b1;
    exe_dest     = 4'd3;
    exe_mem_read = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset_stall_cycles", int'(stall_cycles), 0);
    chk("reset_flush_events", int'(flush_events), 0);
    chk("reset_hang", int'(hang_err), 0);

    // Load-use with forwarding: one stall cycle.
    load_use();
    #1 chk("lu_stall", int'(stall), 1);
    chk("lu_flush", int'(flush), 0);
    tick();
    exe_wb_en = 1'b0;
    #1 chk("lu_stall_gone", int'(stall), 0);
    chk("lu_count", int'(stall_cycles), 1);
    chk("lu_hang", int'(hang_err), 0);
    tick();

    // MEM match is forwarded when forwarding is on, stalls when it is off.
    mem_wb_en = 1'b1;
    mem_dest  = 4'd3;
    #1 chk("mem_fwd_on", int'(stall), 0);
    forward_en = 1'b0;
    #1 chk("mem_fwd_off", int'(stall), 1);
    tick();

    // src2 match only counts when two_src is set.
    src1     = 4'd1;
    src2     = 4'd5;
    two_src  = 1'b1;
    mem_dest = 4'd5;
    #1 chk("src2_used", int'(stall), 1);
    two_src = 1'b0;
    #1 chk("src2_unused", int'(stall), 0);
    tick();
    clear_in();

    // Taken branch voids the hazard and flushes.
    load_use();
    branch_taken = 1'b1;
    #1 chk("br_stall", int'(stall), 0);
    chk("br_flush", int'(flush), 1);
    tick();
    chk("br_flush_events", int'(flush_events), 1);
    chk("br_stall_cycles", int'(stall_cycles), 2);
    branch_taken = 1'b0;

    // Watchdog: four consecutive stall cycles trip it.
    #1 chk("wd_stall", int'(stall), 1);
    ticks(3);
    chk("wd_hang_after3", int'(hang_err), 0);
    chk("wd_count3", int'(stall_cycles), 5);
    tick();
    chk("wd_hang_after4", int'(hang_err), 1);
    chk("wd_count4", int'(stall_cycles), 6);
    chk("wd_stall_kept", int'(stall), 1);
    exe_wb_en = 1'b0;
    tick();
    chk("wd_sticky", int'(hang_err), 1);
    do_reset();
    chk("wd_rst_hang", int'(hang_err), 0);
    chk("wd_rst_count", int'(stall_cycles), 0);
    chk("wd_rst_flush", int'(flush_events), 0);

    // Reset in the middle of a stall run.
    load_use();
    ticks(2);
    chk("mid_count", int'(stall_cycles), 2);
    rst = 1'b1;
    #1 chk("mid_stall_in_rst", int'(stall), 1);
    tick();
    chk("mid_rst_count", int'(stall_cycles), 0);
    chk("mid_rst_hang", int'(hang_err), 0);
    rst = 1'b0;
    tick();
    chk("mid_restart", int'(stall_cycles), 1);
    ticks(2);
    chk("mid_run3_hang", int'(hang_err), 0);
    tick();
    chk("mid_run4_hang", int'(hang_err), 1);

    // Saturation of both counters.
    do_reset();
    ticks(20);
    chk("sat_stall", int'(stall_cycles), 15);
    ticks(2);
    chk("sat_stall_hold", int'(stall_cycles), 15);
    clear_in();
    branch_taken = 1'b1;
    ticks(17);
    chk("sat_flush", int'(flush_events), 15);
    chk("sat_flush_out", int'(flush), 1);
    clear_in();

    // Simultaneous EXE and MEM match is a single stall.
    do_reset();
    id_valid  = 1'b1;
    src1      = 4'd2;
    exe_wb_en = 1'b1;
    exe_dest  = 4'd2;
    mem_wb_en = 1'b1;
    mem_dest  = 4'd2;
    #1 chk("dual_stall", int'(stall), 1);
    tick();
    chk("dual_count", int'(stall_cycles), 1);
    clear_in();
    tick();

    // Registers 0 and 15 match like any other.
    id_valid  = 1'b1;
    exe_wb_en = 1'b1;
    #1 chk("reg0_stall", int'(stall), 1);
    id_valid = 1'b0;
    #1 chk("reg0_invalid", int'(stall), 0);
    tick();
    clear_in();
    id_valid  = 1'b1;
    src1      = 4'd2;
    src2      = 4'd15;
    two_src   = 1'b1;
    mem_wb_en = 1'b1;
    mem_dest  = 4'd15;
    #1 chk("reg15_stall", int'(stall), 1);
    forward_en = 1'b1;
    #1 chk("reg15_fwd", int'(stall), 0);
    tick();

    // Forwarding on: EXE match stalls only for a load.
    exe_wb_en = 1'b1;
    exe_dest  = 4'd2;
    #1 chk("exe_alu_fwd", int'(stall), 0);
    exe_mem_read = 1'b1;
    #1 chk("exe_load_fwd", int'(stall), 1);
    tick();
    clear_in();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard controller for the 5-stage ARM-subset core.
- Sits at the ID stage, next to the forwarding unit.
- Decides each cycle whether to freeze IF/ID and inject a bubble into ID/EX (stall), or discard the fetched instruction because a branch was taken (flush).
- Also keeps a consecutive-stall watchdog and saturating stall/flush event counters for debug and performance readout.

Parameters:
- REG_W, 4, register address width.
- CNT_W, 16, width of the performance counters.
- MAX_STALL, 3, longest legal run of consecutive stall cycles before the watchdog trips.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- forward_en  in  1  1 = forwarding unit active (load-use stalls only); 0 = full RAW stalling.
- id_valid  in  1  ID holds a real instruction.
- src1  in  REG_W  ID first source register.
- src2  in  REG_W  ID second source register.
- two_src  in  1  ID instruction reads src2.
- exe_wb_en  in  1  EXE-stage instruction writes back.
- exe_dest  in  REG_W  EXE-stage destination.
- exe_mem_read  in  1  EXE-stage instruction is a load.
- mem_wb_en  in  1  MEM-stage instruction writes back.
- mem_dest  in  REG_W  MEM-stage destination.
- branch_taken  in  1  branch resolved taken in EXE this cycle.
- stall  out  1  freeze PC and IF/ID; zero ID/EX control.
- flush  out  1  clear IF/ID.
- hang_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_events  out  CNT_W  saturating count of flush cycles.

Behaviour:
- m_exe = exe_wb_en & ((src1==exe_dest) | (two_src & src2==exe_dest)).
- m_mem = mem_wb_en & ((src1==mem_dest) | (two_src & src2==mem_dest)).
- hazard (forward_en=0) = id_valid & (m_exe | m_mem).
- hazard (forward_en=1) = id_valid & m_exe & exe_mem_read. MEM-stage matches are resolved by forwarding.
- stall = hazard & ~branch_taken. A taken branch discards the ID instruction, so its hazard is void.
- flush = branch_taken.
- stall and flush are combinational from the current inputs (zero latency).
- forward_en is sampled combinationally every cycle; toggling it mid-run takes effect in the same cycle.
- FSM states: RUN, STALLING.
  - RUN -> STALLING when stall=1.
  - STALLING stays while stall=1; returns to RUN when stall=0.
  - branch_taken in any state -> RUN next cycle (it forces stall=0).
- run_cnt (width clog2(MAX_STALL+2)):
  - RUN: loads 1 if stall=1, else 0.
  - STALLING: increments while stall=1, saturating at MAX_STALL+1; clears to 0 when stall=0.
- hang_err is set on the rising edge where run_cnt would exceed MAX_STALL, i.e. on the (MAX_STALL+1)-th consecutive stall cycle.
  - It stays 1 until rst and does not alter stall.
- stall_cycles increments by 1 each cycle stall=1; flush_events increments by 1 each cycle flush=1. Both hold at all-ones (no wrap).
- Reset: state=RUN, run_cnt=0, hang_err=0, stall_cycles=0, flush_events=0.
  - stall/flush are driven by the combinational rule during rst; counters do not count while rst=1.
  - Reset mid-stall returns to RUN on the next edge with all counters cleared.
- Simultaneous EXE and MEM matches: a single stall; no double count.
- Register address 0 and 15 are not special-cased; matching is purely by value.

Test Plan:
- Load-use, forwarding on: forward_en=1, id_valid=1, src1=3, exe_wb_en=1, exe_dest=3, exe_mem_read=1 for 1 cycle, then exe_wb_en=0 -> stall=1 for exactly 1 cycle, stall_cycles=1, hang_err=0.
- Forwarding off, MEM match: forward_en=0, src2=5, two_src=1, mem_wb_en=1, mem_dest=5 -> stall=1. Same with two_src=0 -> stall=0.
- Branch beats hazard: the load-use case above plus branch_taken=1 -> stall=0, flush=1, flush_events=1, stall_cycles unchanged, state RUN.
- Watchdog: hold the hazard inputs for 4 cycles with MAX_STALL=3 -> hang_err rises after the 4th stall edge; remove the hazard -> hang_err stays 1; rst=1 for one cycle -> hang_err=0, stall_cycles=0.
- Saturation: CNT_W=4, hold stall for 20 cycles -> stall_cycles=15 and stays at 15.
- Reset mid-stall: stall active 2 cycles, assert rst -> next cycle run_cnt=0, state RUN, counters 0. Remove rst with the hazard still present -> stall_cycles counts from 1.
